// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: streams pixel_count pixels from a source RAM through an
// external combinational filter into a destination RAM, four cycles per pixel.
module frame_seq_ctrl #(
  parameter int ADDR_BITS = 13,
  parameter int PIX_W     = 24,
  parameter int RET_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS:0]   pixel_count,
  output logic [ADDR_BITS-1:0] src_addr,
  input  logic [PIX_W-1:0]     src_do,
  output logic [PIX_W-1:0]     filt_pixel,
  input  logic [RET_W-1:0]     filt_ret,
  output logic [ADDR_BITS-1:0] dst_addr,
  output logic [PIX_W-1:0]     dst_di,
  output logic                 dst_we,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   progress
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_APPLY = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [ADDR_BITS:0]     count_r;
  logic [ADDR_BITS:0]     progress_r;
  logic [PIX_W-1:0]       pix_r;
  logic                   accept_s;
  logic                   last_s;

  // start is only honoured in IDLE and loses to a simultaneous abort
  assign accept_s = (state_r == S_IDLE) && start && !abort;

  // count is one bit wider than addr so a full-range pass ends at the top address
  assign last_s = ({1'b0, addr_r} == (count_r - {{ADDR_BITS{1'b0}}, 1'b1}));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort overrides every transition out of a busy state
  always_comb begin
    state_nxt_s = state_r;
    if (abort && (state_r != S_IDLE)) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (pixel_count != {(ADDR_BITS+1){1'b0}}) begin
              state_nxt_s = S_READ;
            end else begin
              state_nxt_s = S_DONE;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_READ:  state_nxt_s = S_APPLY;
        S_APPLY: state_nxt_s = S_WRITE;
        S_WRITE: state_nxt_s = S_NEXT;
        S_NEXT: begin
          if (last_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_READ;
          end
        end
        S_DONE:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Datapath registers: latched count, pixel address, captured pixel, progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r     <= {ADDR_BITS{1'b0}};
      count_r    <= {(ADDR_BITS+1){1'b0}};
      progress_r <= {(ADDR_BITS+1){1'b0}};
      pix_r      <= {PIX_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            count_r    <= pixel_count;
            addr_r     <= {ADDR_BITS{1'b0}};
            progress_r <= {(ADDR_BITS+1){1'b0}};
          end
        end
        S_APPLY: begin
          if (!abort) begin
            pix_r <= src_do;
          end
        end
        S_NEXT: begin
          if (!abort) begin
            progress_r <= progress_r + {{ADDR_BITS{1'b0}}, 1'b1};
            if (!last_s) begin
              addr_r <= addr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state; only the write strobe sees abort directly
  always_comb begin
    src_addr   = addr_r;
    dst_addr   = addr_r;
    filt_pixel = pix_r;
    dst_di     = {3{filt_ret}};
    progress   = progress_r;
    busy       = (state_r != S_IDLE);
    done       = (state_r == S_DONE);
    if ((state_r == S_WRITE) && !abort) begin
      dst_we = 1'b1;
    end else begin
      dst_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl: a default-width instance for the
// functional passes and a 4-bit-address instance for the full-range pass.
module tb_frame_seq_ctrl;

  localparam int AB  = 13;
  localparam int AB4 = 4;
  localparam int PW  = 24;
  localparam int RW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, start4;
  logic [AB:0]    pixel_count, progress;
  logic [AB-1:0]  src_addr, dst_addr;
  logic [PW-1:0]  src_do, filt_pixel, dst_di;
  logic [RW-1:0]  filt_ret;
  logic           dst_we, busy, done;
  logic [AB4:0]   pixel_count4, progress4;
  logic [AB4-1:0] src_addr4, dst_addr4;
  logic [PW-1:0]  src_do4, filt_pixel4, dst_di4;
  logic [RW-1:0]  filt_ret4;
  logic           dst_we4, busy4, done4;

  logic [PW-1:0]  src_mem [0:31];
  logic [AB-1:0]  addr_q[$];
  logic [PW-1:0]  data_q[$];
  logic [AB4-1:0] addr4_q[$];
  logic [PW-1:0]  data4_q[$];
  int checks = 0;
  int errors = 0;

  frame_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pixel_count(pixel_count), .src_addr(src_addr), .src_do(src_do),
    .filt_pixel(filt_pixel), .filt_ret(filt_ret), .dst_addr(dst_addr),
    .dst_di(dst_di), .dst_we(dst_we), .busy(busy), .done(done),
    .progress(progress)
  );

  frame_seq_ctrl #(.ADDR_BITS(AB4), .PIX_W(PW), .RET_W(RW)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
    .pixel_count(pixel_count4), .src_addr(src_addr4), .src_do(src_do4),
    .filt_pixel(filt_pixel4), .filt_ret(filt_ret4), .dst_addr(dst_addr4),
    .dst_di(dst_di4), .dst_we(dst_we4), .busy(busy4), .done(done4),
    .progress(progress4)
  );

  function automatic logic [RW-1:0] mean3(input logic [PW-1:0] p);
    logic [9:0] s;
    s = 10'(p[23:16]) + 10'(p[15:8]) + 10'(p[7:0]);
    return RW'(s / 10'd3);
  endfunction

  // filter = mean of the three bytes; source RAM has one cycle read latency
  assign filt_ret  = mean3(filt_pixel);
  assign filt_ret4 = mean3(filt_pixel4);
  always @(posedge clk) begin
    src_do  <= src_mem[src_addr[4:0]];
    src_do4 <= src_mem[{1'b0, src_addr4}];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(AB'(i));
      data_q.push_back({3{mean3(src_mem[i])}});
    end
  endtask

  // destination write monitors pop the scoreboard
  always @(negedge clk) begin
    if (dst_we === 1'b1) begin
      if (addr_q.size() == 0) begin
        check("write_expected", 64'(addr_q.size()), 64'd1);
      end else begin
        check("wr_addr", 64'(dst_addr), 64'(addr_q.pop_front()));
        check("wr_data", 64'(dst_di), 64'(data_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (dst_we4 === 1'b1) begin
      if (addr4_q.size() == 0) begin
        check("write4_expected", 64'(addr4_q.size()), 64'd1);
      end else begin
        check("wr4_addr", 64'(dst_addr4), 64'(addr4_q.pop_front()));
        check("wr4_data", 64'(dst_di4), 64'(data4_q.pop_front()));
      end
    end
  end

  task automatic start_pass(input int n);
    @(negedge clk);
    pixel_count = (AB+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // counts cycles after the acceptance edge until done, then checks the pulse ended
  task automatic wait_done(input string tag, input int exp_cyc, input int prog);
    int cyc;
    cyc = 0;
    for (int i = 1; (i <= exp_cyc + 8) && (cyc == 0); i++) begin
      @(negedge clk);
      if (done) cyc = i;
    end
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_progress"}, 64'(progress), 64'(prog));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_writes_left"}, 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, d1, d2, cyc4;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pixel_count = '0;
    start4 = 1'b0; pixel_count4 = '0;
    src_mem[0] = 24'h102030;
    src_mem[1] = 24'h405060;
    src_mem[2] = 24'h708090;
    for (int i = 3; i < 32; i++) src_mem[i] = 24'($urandom);

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(dst_we), 64'd0);
    check("rst_src_addr", 64'(src_addr), 64'd0);
    check("rst_dst_addr", 64'(dst_addr), 64'd0);
    check("rst_filt_pixel", 64'(filt_pixel), 64'd0);
    check("rst_progress", 64'(progress), 64'd0);
    check("rst4_busy", 64'(busy4), 64'd0);
    reset = 1'b1;

    // three-pixel reference pass
    push_exp(3);
    start_pass(3);
    wait_done("basic", 13, 3);
    check("basic_dst_word2", 64'({3{mean3(src_mem[2])}}), 64'h808080);

    // empty pass: done next cycle, no write
    start_pass(0);
    wait_done("zero", 1, 0);

    // abort in APPLY of pixel 2
    push_exp(2);
    start_pass(5);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_progress", 64'(progress), 64'd2);
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    check("abort_writes_left", 64'(addr_q.size()), 64'd0);

    // abort during WRITE suppresses the strobe
    start_pass(2);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_we_gated", 64'(dst_we), 64'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_wr_busy", 64'(busy), 64'd0);
    check("abort_wr_progress", 64'(progress), 64'd0);

    // start with abort in IDLE is ignored
    @(negedge clk);
    pixel_count = 14'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 64'(busy), 64'd0);

    // start held high, pixel_count changed mid-pass
    push_exp(3);
    push_exp(2);
    @(negedge clk);
    pixel_count = 14'd3; start = 1'b1;
    @(posedge clk);
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 5) pixel_count = 14'd2;
      if (c == 16) start = 1'b0;
      if (c == 14) check("held_gap_idle", 64'(busy), 64'd0);
      if (c == 15) check("held_second_busy", 64'(busy), 64'd1);
      if (done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    check("held_first_done", 64'(d1), 64'd13);
    check("held_second_done", 64'(d2), 64'd23);
    check("held_progress", 64'(progress), 64'd2);
    check("held_writes_left", 64'(addr_q.size()), 64'd0);

    // asynchronous reset during WRITE of pixel 0
    push_exp(1);
    start_pass(3);
    repeat (3) @(negedge clk);
    check("prereset_we", 64'(dst_we), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_we", 64'(dst_we), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_src_addr", 64'(src_addr), 64'd0);
    check("async_dst_addr", 64'(dst_addr), 64'd0);
    check("async_filt_pixel", 64'(filt_pixel), 64'd0);
    check("async_progress", 64'(progress), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_exp(1);
    pixel_count = 14'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("after_reset", 5, 1);

    // full-range pass on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      addr4_q.push_back(AB4'(i));
      data4_q.push_back({3{mean3(src_mem[i])}});
    end
    @(negedge clk);
    pixel_count4 = 5'd16; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    cyc4 = 0;
    for (int i = 1; (i <= 80) && (cyc4 == 0); i++) begin
      @(negedge clk);
      if (done4) begin
        cyc4 = i;
        check("full_final_addr", 64'(src_addr4), 64'd15);
        check("full_progress", 64'(progress4), 64'd16);
      end
    end
    check("full_done_cycle", 64'(cyc4), 64'd65);
    check("full_writes_left", 64'(addr4_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
